// File: rtl/midi_voice_alloc_pkg.sv
// Shared types for the MIDI voice allocator: voice slot layout, event kinds, FSM states.
// Optional feature macro used by this slice: VOICE_ALLOC_STEAL_EN.
package midi_voice_alloc_pkg;

    localparam int unsigned MidiBits      = 7;
    localparam int unsigned DefaultVoices = 4;

    typedef struct packed {
        logic                gate;
        logic [MidiBits-1:0] note;
        logic [MidiBits-1:0] velocity;
    } voice_t;

    typedef enum logic [1:0] {EvNone, EvOn, EvOff} ev_kind_e;

    typedef enum logic [1:0] {StIdle, StCapture, StApply} state_e;

    // Velocity 0 with value=1 is a note-off by MIDI running-status convention.
    function automatic ev_kind_e classify(logic value, logic [MidiBits-1:0] note,
                                          logic [MidiBits-1:0] velocity);
        if (value) begin
            return (velocity == '0) ? EvOff : EvOn;
        end
        return (note == '0) ? EvNone : EvOff;
    endfunction

endpackage

// File: rtl/midi_voice_alloc_if.sv
// Event bundle from the MIDI receiver into the voice allocator.
// Optional feature macro used by this slice: VOICE_ALLOC_STEAL_EN.
interface midi_voice_alloc_if;
    import midi_voice_alloc_pkg::*;

    logic                ready;
    logic                value;
    logic [MidiBits-1:0] note;
    logic [MidiBits-1:0] velocity;

    modport master (output ready, value, note, velocity);
    modport slave  (input  ready, value, note, velocity);

endinterface

// File: rtl/midi_voice_alloc_voice_pick.sv
// Combinational priority selector: lowest-index candidate, or with use_age_i the oldest
// candidate (ties to lowest index). Optional feature macro of this slice: VOICE_ALLOC_STEAL_EN.
module voice_pick #(
    parameter int unsigned N        = 4,
    parameter int unsigned AGE_BITS = 4,
    localparam int unsigned IdxW    = $clog2(N)
) (
    input  logic [N-1:0]               cand_i,
    input  logic [N-1:0][AGE_BITS-1:0] age_i,
    input  logic                       use_age_i,
    output logic [IdxW-1:0]            idx_o,
    output logic                       found_o
);

    logic                found;
    logic [IdxW-1:0]     idx;
    logic [AGE_BITS-1:0] best;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        best  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // Strict compare keeps the lowest index on equal ages.
            if (cand_i[i] && (!found || (use_age_i && age_i[i] > best))) begin
                found = 1'b1;
                idx   = IdxW'(i);
                best  = age_i[i];
            end
        end
    end

    assign idx_o   = idx;
    assign found_o = found;

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto voice slots.
// Macro VOICE_ALLOC_STEAL_EN enables oldest-voice stealing; otherwise surplus notes drop.
module midi_voice_alloc
    import midi_voice_alloc_pkg::*;
#(
    parameter int unsigned VOICES   = DefaultVoices,
    parameter int unsigned AGE_BITS = 4,
    localparam int unsigned IdxW    = $clog2(VOICES),
    localparam int unsigned CntW    = $clog2(VOICES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    midi_voice_alloc_if.slave    midi,
    output voice_t [VOICES-1:0]  voice,
    output logic [CntW-1:0]      active,
`ifndef VOICE_ALLOC_STEAL_EN
    output logic                 dropped,
`endif
    output logic                 busy
);

    state_e                          state_q, state_d;
    logic                            last_ready_q;
    ev_kind_e                        ev_kind_q, ev_in;
    logic [MidiBits-1:0]             ev_note_q, ev_vel_q;
    logic [IdxW-1:0]                 sel_q, sel_d;
    logic                            sel_ok_q, sel_ok_d;
    voice_t [VOICES-1:0]             voice_q, voice_d;
    logic [VOICES-1:0][AGE_BITS-1:0] age_q, age_d;
    logic [CntW-1:0]                 active_q, active_d;
    logic                            ev_det, cap_en, pick_en, apply_en;

    logic [VOICES-1:0] gate_vec, match_vec;
    logic [IdxW-1:0]   match_idx, free_idx;
    logic              match_found, free_found;

    assign ev_det = midi.ready & ~last_ready_q;
    assign ev_in  = classify(midi.value, midi.note, midi.velocity);

    always_comb begin
        gate_vec  = '0;
        match_vec = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            gate_vec[i]  = voice_q[i].gate;
            match_vec[i] = voice_q[i].gate && (voice_q[i].note == ev_note_q);
        end
    end

    voice_pick #(.N(VOICES), .AGE_BITS(AGE_BITS)) u_pick_match (
        .cand_i    (match_vec),
        .age_i     (age_q),
        .use_age_i (1'b0),
        .idx_o     (match_idx),
        .found_o   (match_found)
    );

    voice_pick #(.N(VOICES), .AGE_BITS(AGE_BITS)) u_pick_free (
        .cand_i    (~gate_vec),
        .age_i     (age_q),
        .use_age_i (1'b0),
        .idx_o     (free_idx),
        .found_o   (free_found)
    );

`ifdef VOICE_ALLOC_STEAL_EN
    logic [IdxW-1:0] old_idx;
    logic            old_found;

    voice_pick #(.N(VOICES), .AGE_BITS(AGE_BITS)) u_pick_oldest (
        .cand_i    (gate_vec),
        .age_i     (age_q),
        .use_age_i (1'b1),
        .idx_o     (old_idx),
        .found_o   (old_found)
    );
`endif

    always_comb begin
        state_d  = state_q;
        cap_en   = 1'b0;
        pick_en  = 1'b0;
        apply_en = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ev_det && ev_in != EvNone) begin
                    state_d = StCapture;
                    cap_en  = 1'b1;
                end
            end
            StCapture: begin
                state_d = StApply;
                pick_en = 1'b1;
            end
            StApply: begin
                state_d  = StIdle;
                apply_en = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Retrigger beats a free slot, which beats stealing.
    always_comb begin
        sel_d    = match_idx;
        sel_ok_d = 1'b0;
        if (ev_kind_q == EvOn) begin
            if (match_found) begin
                sel_d    = match_idx;
                sel_ok_d = 1'b1;
            end else if (free_found) begin
                sel_d    = free_idx;
                sel_ok_d = 1'b1;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                sel_d    = old_idx;
                sel_ok_d = old_found;
`else
                sel_ok_d = 1'b0;
`endif
            end
        end
    end

    always_comb begin
        voice_d = voice_q;
        age_d   = age_q;
        if (apply_en) begin
            for (int unsigned i = 0; i < VOICES; i++) begin
                if (ev_kind_q == EvOn && sel_ok_q) begin
                    if (IdxW'(i) == sel_q) begin
                        voice_d[i].gate     = 1'b1;
                        voice_d[i].note     = ev_note_q;
                        voice_d[i].velocity = ev_vel_q;
                        age_d[i]            = '0;
                    end else if (voice_q[i].gate && age_q[i] != '1) begin
                        age_d[i] = age_q[i] + AGE_BITS'(1);
                    end
                end else if (ev_kind_q == EvOff) begin
                    // Note and velocity are kept so the envelope can release.
                    if (voice_q[i].gate && voice_q[i].note == ev_note_q) begin
                        voice_d[i].gate = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        active_d = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (voice_d[i].gate) begin
                active_d = active_d + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_ready_q <= 1'b0;
            ev_kind_q    <= EvNone;
            ev_note_q    <= '0;
            ev_vel_q     <= '0;
            sel_q        <= '0;
            sel_ok_q     <= 1'b0;
            voice_q      <= '0;
            age_q        <= '0;
            active_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_ready_q <= midi.ready;
            if (cap_en) begin
                ev_kind_q <= ev_in;
                ev_note_q <= midi.note;
                ev_vel_q  <= midi.velocity;
            end
            if (pick_en) begin
                sel_q    <= sel_d;
                sel_ok_q <= sel_ok_d;
            end
            voice_q  <= voice_d;
            age_q    <= age_d;
            active_q <= active_d;
        end
    end

    assign voice  = voice_q;
    assign active = active_q;
    assign busy   = (state_q != StIdle);
`ifndef VOICE_ALLOC_STEAL_EN
    assign dropped = (state_q == StApply) && (ev_kind_q == EvOn) && !sel_ok_q;
`endif

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Bench for midi_voice_alloc: event-level voice model checked every cycle plus directed
// literal checks. Honours VOICE_ALLOC_STEAL_EN the same way as the design.
module tb_midi_voice_alloc;
    import midi_voice_alloc_pkg::*;

    localparam int V  = 4;
    localparam int AB = 4;
`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit Steal = 1'b1;
`else
    localparam bit Steal = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    midi_voice_alloc_if midi ();
    voice_t [V-1:0] voice;
    logic [2:0]     active;
    logic           busy;
`ifndef VOICE_ALLOC_STEAL_EN
    logic           dropped;
    int             drop_pulses = 0;
`endif

    midi_voice_alloc #(.VOICES(V), .AGE_BITS(AB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .midi   (midi),
        .voice  (voice),
        .active (active),
`ifndef VOICE_ALLOC_STEAL_EN
        .dropped(dropped),
`endif
        .busy   (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] vexp(bit g, int n, int v);
        logic [31:0] r;
        r = {17'b0, g, n[6:0], v[6:0]};
        return r;
    endfunction

    // Event-level model: slot contents, ages and the event pipeline countdown.
    bit m_gate[V];
    int m_note[V], m_vel[V], m_age[V];
    bit m_last, m_drop;
    int m_cd, m_kind, m_evn, m_evv;

    function automatic int kind_of(bit val, int n, int v);
        if (!val && n == 0) return 0;
        if (val && v == 0)  return 2;
        if (val)            return 1;
        return 2;
    endfunction

    function automatic int m_pick();
        int s = -1;
        int best = -1;
        for (int i = 0; i < V; i++) if (s < 0 && m_gate[i] && m_note[i] == m_evn) s = i;
        for (int i = 0; i < V; i++) if (s < 0 && !m_gate[i]) s = i;
        if (s < 0 && Steal) begin
            for (int i = 0; i < V; i++) begin
                if (m_gate[i] && m_age[i] > best) begin
                    best = m_age[i];
                    s = i;
                end
            end
        end
        return s;
    endfunction

    task automatic m_apply();
        int s;
        if (m_kind == 1) begin
            s = m_pick();
            if (s >= 0) begin
                for (int i = 0; i < V; i++) begin
                    if (i == s) begin
                        m_gate[i] = 1'b1; m_note[i] = m_evn; m_vel[i] = m_evv; m_age[i] = 0;
                    end else if (m_gate[i] && m_age[i] < (1 << AB) - 1) begin
                        m_age[i]++;
                    end
                end
            end
        end else begin
            for (int i = 0; i < V; i++) if (m_gate[i] && m_note[i] == m_evn) m_gate[i] = 1'b0;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < V; i++) begin
            m_gate[i] = 1'b0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
        m_last = 1'b0; m_drop = 1'b0; m_cd = 0; m_kind = 0; m_evn = 0; m_evv = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                if (m_cd == 0) begin
                    if (midi.ready && !m_last &&
                        kind_of(midi.value, int'(midi.note), int'(midi.velocity)) != 0) begin
                        m_kind = kind_of(midi.value, int'(midi.note), int'(midi.velocity));
                        m_evn  = int'(midi.note);
                        m_evv  = int'(midi.velocity);
                        m_cd   = 2;
                    end
                end else if (m_cd == 2) begin
                    m_cd   = 1;
                    m_drop = (m_kind == 1) && (m_pick() < 0);
                end else begin
                    m_cd   = 0;
                    m_drop = 1'b0;
                    m_apply();
                end
                m_last = midi.ready;
            end
        end
    end

    initial begin
        int cnt;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cnt = 0;
                for (int i = 0; i < V; i++) begin
                    check("model_voice", 32'(voice[i]), vexp(m_gate[i], m_note[i], m_vel[i]));
                    if (m_gate[i]) cnt++;
                end
                check("model_active", 32'(active), 32'(cnt));
                check("model_busy", 32'(busy), 32'(m_cd != 0));
`ifndef VOICE_ALLOC_STEAL_EN
                check("model_dropped", 32'(dropped), 32'(m_drop));
                if (dropped) drop_pulses++;
`endif
            end
        end
    end

    task automatic drive(bit val, int n, int v);
        midi.value    = val;
        midi.note     = n[6:0];
        midi.velocity = v[6:0];
    endtask

    task automatic send(bit val, int n, int v);
        @(negedge clk);
        drive(val, n, v);
        midi.ready = 1'b1;
        repeat (3) @(negedge clk);
        midi.ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        midi.ready = 1'b0;
        drive(1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_voice0", 32'(voice[0]), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // First note: outputs move on the third edge after ready rises.
        @(negedge clk);
        drive(1'b1, 60, 100);
        midi.ready = 1'b1;
        @(posedge clk); #1;
        check("lat_busy_e1", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("lat_gate_e2", 32'(voice[0].gate), 32'd0);
        @(posedge clk); #1;
        check("lat_voice_e3", 32'(voice[0]), vexp(1, 60, 100));
        check("lat_active_e3", 32'(active), 32'd1);
        check("lat_busy_e3", 32'(busy), 32'd0);
        @(negedge clk);
        midi.ready = 1'b0;
        repeat (2) @(negedge clk);

        // Fill all four slots, then one and two more notes.
        do_reset();
        send(1'b1, 60, 10);
        send(1'b1, 62, 20);
        send(1'b1, 64, 30);
        send(1'b1, 65, 40);
`ifndef VOICE_ALLOC_STEAL_EN
        drop_pulses = 0;
`endif
        send(1'b1, 67, 77);
        check("full_active", 32'(active), 32'd4);
        check("full_v0", 32'(voice[0]), Steal ? vexp(1, 67, 77) : vexp(1, 60, 10));
        check("full_v3", 32'(voice[3]), vexp(1, 65, 40));
`ifndef VOICE_ALLOC_STEAL_EN
        check("drop_pulses", 32'(drop_pulses), 32'd1);
`endif
        send(1'b1, 69, 88);
        check("full_v1", 32'(voice[1]), Steal ? vexp(1, 69, 88) : vexp(1, 62, 20));
        check("full_v2", 32'(voice[2]), vexp(1, 64, 30));

        // Reset while the next event sits in capture.
        @(negedge clk);
        drive(1'b1, 70, 1);
        midi.ready = 1'b1;
        @(posedge clk); #1;
        check("midcap_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midcap_v0", 32'(voice[0]), 32'd0);
        check("midcap_v3", 32'(voice[3]), 32'd0);
        check("midcap_active", 32'(active), 32'd0);
        check("midcap_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        midi.ready = 1'b0;
        rst_n = 1'b1;

        // Velocity-0 note-off keeps note and velocity; value=0 form also releases.
        send(1'b1, 60, 100);
        send(1'b1, 60, 0);
        check("off_v0", 32'(voice[0]), vexp(0, 60, 100));
        check("off_active", 32'(active), 32'd0);
        send(1'b1, 61, 5);
        send(1'b0, 61, 0);
        check("off2_v0", 32'(voice[0]), vexp(0, 61, 5));

        // Retrigger reuses the slot.
        do_reset();
        send(1'b1, 60, 50);
        send(1'b1, 60, 90);
        check("retrig_v0", 32'(voice[0]), vexp(1, 60, 90));
        check("retrig_v1", 32'(voice[1]), 32'd0);
        check("retrig_active", 32'(active), 32'd1);

        // Second rise during busy is ignored.
        do_reset();
        @(negedge clk);
        drive(1'b1, 60, 100);
        midi.ready = 1'b1;
        @(negedge clk);
        midi.ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 62, 50);
        midi.ready = 1'b1;
        repeat (4) @(negedge clk);
        midi.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("busydrop_active", 32'(active), 32'd1);
        check("busydrop_v1", 32'(voice[1]), 32'd0);

        // Ready already high when reset releases counts as an event.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 64, 9);
        midi.ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstready_v0", 32'(voice[0]), vexp(1, 64, 9));
        midi.ready = 1'b0;
        repeat (2) @(negedge clk);

        // Controller event held high: ignored, and no repeat events.
        @(negedge clk);
        drive(1'b0, 0, 64);
        midi.ready = 1'b1;
        repeat (1000) @(negedge clk);
        midi.ready = 1'b0;
        repeat (2) @(negedge clk);
        check("ctrl_v0", 32'(voice[0]), vexp(1, 64, 9));
        check("ctrl_active", 32'(active), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
